store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered stores (power of two, >=2).
REQ-002 The block SHALL have parameter AW, default 64, giving the address width.
REQ-003 The block SHALL have parameter DW, default 64, giving the data width.
REQ-004 clk  input  1  Single clock; all state updates on its rising edge.
REQ-005 reset  input  1  Asynchronous, active-low reset.
REQ-006 EnableMemoryWrite  input  1  Store request from the core memory stage.
REQ-007 AddressToWriteIntoMemory  input  AW  Store address.
REQ-008 DataToWriteIntoMemory  input  DW  Store data.
REQ-009 StoreStall  output  1  Buffer full; the core holds its store.
REQ-010 LoadValid  input  1  The core is issuing a load this cycle.
REQ-011 LoadAddress  input  AW  Load address used for forwarding lookup.
REQ-012 ForwardHit  output  1  A buffered store matches LoadAddress.
REQ-013 ForwardData  output  DW  Data of the youngest matching store.
REQ-014 MemWriteReq  output  1  Write request to data memory.
REQ-015 MemWriteAddr  output  AW  Write address to data memory.
REQ-016 MemWriteData  output  DW  Write data to data memory.
REQ-017 MemWriteAck  input  1  Data memory accepted the current write.
REQ-018 Count  output  $clog2(DEPTH)+1  Number of valid entries.
REQ-019 Empty  output  1  Count==0.

Function
REQ-020 The buffer SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH; store order SHALL be preserved, and same-address stores SHALL NOT be merged.
REQ-021 StoreStall SHALL be combinational: high iff Count==DEPTH.
REQ-022 The buffer SHALL enqueue at the tail on a rising edge where EnableMemoryWrite=1 and StoreStall=0; EnableMemoryWrite while StoreStall=1 SHALL be ignored, with no state change.
REQ-023 The drain FSM SHALL have states IDLE and REQ; IDLE->REQ when Count>0; REQ->REQ on ack with entries remaining after the pop; REQ->IDLE on ack with none remaining.
REQ-024 MemWriteReq SHALL be registered and high exactly in REQ; MemWriteAddr/MemWriteData SHALL present the head entry and stay stable until MemWriteAck is sampled high.
REQ-025 A sampled MemWriteAck in REQ SHALL pop the head; MemWriteAck in IDLE SHALL be ignored.
REQ-026 Latency: a store enqueued into an empty buffer at edge N SHALL produce MemWriteReq=1 after edge N+1; with ack held high, back-to-back entries SHALL drain one per cycle.
REQ-027 A simultaneous enqueue and pop SHALL leave Count unchanged; when full, the pop SHALL proceed and the enqueue SHALL be refused, because StoreStall was high that cycle.
REQ-028 ForwardHit SHALL be combinational: LoadValid=1 and a full-width address equality with any valid entry, including the head in flight.
REQ-029 On multiple matches, ForwardData SHALL return the youngest entry; when ForwardHit=0, ForwardData SHALL be 0.
REQ-030 A store being enqueued in the same cycle SHALL NOT be visible to forwarding until the next cycle.

Reset
REQ-031 When reset=0, asynchronously: pointers=0, Count=0, Empty=1, state=IDLE, MemWriteReq=0, MemWriteAddr=0, MemWriteData=0, StoreStall=0, ForwardHit=0, ForwardData=0.
REQ-032 Reset asserted during REQ SHALL discard all pending entries and drop MemWriteReq immediately without waiting for ack.
REQ-033 After reset deasserts, the first rising edge SHALL accept a store normally.

Verification
REQ-034 Single store: store (0x10, 5), MemWriteAck held 1 -> MemWriteReq high one cycle with addr 0x10 / data 5; then Empty=1, Count=0.
REQ-035 Full and stall: 4 stores (0x0,0x8,0x10,0x18) with ack=0 -> Count=4, StoreStall=1; a 5th store (0x20) is dropped; then ack=1 drains 0x0,0x8,0x10,0x18 in order.
REQ-036 Forwarding: stores (0x20,1) then (0x20,2), ack=0; load 0x20 -> ForwardHit=1, ForwardData=2; load 0x28 -> ForwardHit=0, ForwardData=0.
REQ-037 Simultaneous: Count=2 in REQ, store plus ack in the same cycle -> Count stays 2, head advances, new entry at the tail.
REQ-038 Reset mid-operation: Count=3 in REQ, reset=0 -> MemWriteReq=0 and Count=0 before the next edge; MemWriteAck afterwards is ignored.
REQ-039 Wrap-around: 10 stores interleaved with random ack gaps -> the memory-side sequence equals the enqueue sequence, and StoreStall is never high while Count<4.

Source files
------------

// File: rtl/store_buffer.sv
// Circular store buffer between the core memory stage and data memory.
// Drains the oldest entry through a req/ack handshake and forwards the youngest matching store to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     EnableMemoryWrite,
  input  logic [AW-1:0]            AddressToWriteIntoMemory,
  input  logic [DW-1:0]            DataToWriteIntoMemory,
  output logic                     StoreStall,
  input  logic                     LoadValid,
  input  logic [AW-1:0]            LoadAddress,
  output logic                     ForwardHit,
  output logic [DW-1:0]            ForwardData,
  output logic                     MemWriteReq,
  output logic [AW-1:0]            MemWriteAddr,
  output logic [DW-1:0]            MemWriteData,
  input  logic                     MemWriteAck,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);

  localparam int PW = $clog2(DEPTH);

  // state | meaning
  // IDLE  | nothing being offered to memory
  // REQ   | head entry presented on MemWrite*, waiting for ack
  typedef enum logic {IDLE, REQ} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic          push, pop;
  logic [PW-1:0] fwd_idx;

  assign StoreStall = (count_q == (PW+1)'(DEPTH));
  assign push       = EnableMemoryWrite & ~StoreStall;
  assign pop        = (state_q == REQ) & MemWriteAck;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // The IDLE->REQ decision looks at the current occupancy, so a store into an
  // empty buffer reaches memory one cycle after it is enqueued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ:     if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= AddressToWriteIntoMemory;
      data_q[tail_q] <= DataToWriteIntoMemory;
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    ForwardHit  = 1'b0;
    ForwardData = '0;
    fwd_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if (LoadValid && ((PW+1)'(k) < count_q) && (addr_q[fwd_idx] == LoadAddress)) begin
        ForwardHit  = 1'b1;
        ForwardData = data_q[fwd_idx];
      end
    end
  end

  assign MemWriteReq  = (state_q == REQ);
  assign MemWriteAddr = MemWriteReq ? addr_q[head_q] : '0;
  assign MemWriteData = MemWriteReq ? data_q[head_q] : '0;
  assign Count        = count_q;
  assign Empty        = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run checked against a queue-based model of the buffer.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          EnableMemoryWrite;
  logic [AW-1:0] AddressToWriteIntoMemory;
  logic [DW-1:0] DataToWriteIntoMemory;
  logic          StoreStall;
  logic          LoadValid;
  logic [AW-1:0] LoadAddress;
  logic          ForwardHit;
  logic [DW-1:0] ForwardData;
  logic          MemWriteReq;
  logic [AW-1:0] MemWriteAddr;
  logic [DW-1:0] MemWriteData;
  logic          MemWriteAck;
  logic [2:0]    Count;
  logic          Empty;

  int n_cmp = 0;
  int n_err = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .EnableMemoryWrite(EnableMemoryWrite),
    .AddressToWriteIntoMemory(AddressToWriteIntoMemory),
    .DataToWriteIntoMemory(DataToWriteIntoMemory),
    .StoreStall(StoreStall),
    .LoadValid(LoadValid), .LoadAddress(LoadAddress),
    .ForwardHit(ForwardHit), .ForwardData(ForwardData),
    .MemWriteReq(MemWriteReq), .MemWriteAddr(MemWriteAddr), .MemWriteData(MemWriteData),
    .MemWriteAck(MemWriteAck),
    .Count(Count), .Empty(Empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ack);
    EnableMemoryWrite        = en;
    AddressToWriteIntoMemory = a;
    DataToWriteIntoMemory    = d;
    MemWriteAck              = ack;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    LoadValid = 1'b1; LoadAddress = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (Count !== 3'd0)     begin n_err++; $display("FAIL reset_count got=%0d exp=0", Count); end
    n_cmp++; if (Empty !== 1'b1)     begin n_err++; $display("FAIL reset_empty got=%b exp=1", Empty); end
    n_cmp++; if (MemWriteReq !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", MemWriteReq); end
    n_cmp++; if (MemWriteAddr !== '0 || MemWriteData !== '0) begin n_err++; $display("FAIL reset_memside got=%h/%h exp=0/0", MemWriteAddr, MemWriteData); end
    n_cmp++; if (StoreStall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", StoreStall); end
    n_cmp++; if (ForwardHit !== 1'b0 || ForwardData !== '0) begin n_err++; $display("FAIL reset_fwd got=%b/%h exp=0/0", ForwardHit, ForwardData); end
    LoadValid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 64'h10, 64'd5, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    #1;
    n_cmp++; if (Count !== 3'd1 || MemWriteReq !== 1'b0) begin n_err++; $display("FAIL single_enq count/req got=%0d/%b exp=1/0", Count, MemWriteReq); end
    tick(); #1;
    n_cmp++; if (MemWriteReq !== 1'b1 || MemWriteAddr !== 64'h10 || MemWriteData !== 64'd5) begin
      n_err++; $display("FAIL single_req got=%b %h %h exp=1 10 5", MemWriteReq, MemWriteAddr, MemWriteData); end
    tick(); #1;
    n_cmp++; if (MemWriteReq !== 1'b0 || Empty !== 1'b1 || Count !== 3'd0) begin
      n_err++; $display("FAIL single_done got=req%b empty%b count%0d exp=0 1 0", MemWriteReq, Empty, Count); end
    drive(1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_full();
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 64'(i * 8);
      drive(1'b1, a, a + 64'h100, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0); #1;
    n_cmp++; if (Count !== 3'd4 || StoreStall !== 1'b1) begin n_err++; $display("FAIL full count/stall got=%0d/%b exp=4/1", Count, StoreStall); end
    drive(1'b1, 64'h20, 64'h120, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0); #1;
    n_cmp++; if (Count !== 3'd4 || MemWriteAddr !== 64'h0) begin n_err++; $display("FAIL full_drop count/head got=%0d/%h exp=4/0", Count, MemWriteAddr); end
    MemWriteAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 64'(i * 8);
      #1;
      n_cmp++; if (MemWriteReq !== 1'b1 || MemWriteAddr !== a || MemWriteData !== a + 64'h100) begin
        n_err++; $display("FAIL full_drain%0d got=%b %h %h exp=1 %h %h", i, MemWriteReq, MemWriteAddr, MemWriteData, a, a + 64'h100); end
      tick();
    end
    #1;
    n_cmp++; if (Empty !== 1'b1 || MemWriteReq !== 1'b0) begin n_err++; $display("FAIL full_empty got=%b/%b exp=1/0", Empty, MemWriteReq); end
    MemWriteAck = 1'b0;
  endtask

  task automatic test_forward();
    drive(1'b1, 64'h20, 64'd1, 1'b0);
    LoadValid = 1'b1; LoadAddress = 64'h20; #1;
    n_cmp++; if (ForwardHit !== 1'b0) begin n_err++; $display("FAIL fwd_same_cycle got=%b exp=0", ForwardHit); end
    tick();
    drive(1'b1, 64'h20, 64'd2, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0); #1;
    n_cmp++; if (ForwardHit !== 1'b1 || ForwardData !== 64'd2) begin n_err++; $display("FAIL fwd_youngest got=%b/%h exp=1/2", ForwardHit, ForwardData); end
    LoadAddress = 64'h28; #1;
    n_cmp++; if (ForwardHit !== 1'b0 || ForwardData !== '0) begin n_err++; $display("FAIL fwd_miss got=%b/%h exp=0/0", ForwardHit, ForwardData); end
    LoadAddress = 64'h20; LoadValid = 1'b0; #1;
    n_cmp++; if (ForwardHit !== 1'b0) begin n_err++; $display("FAIL fwd_novalid got=%b exp=0", ForwardHit); end
    LoadValid = 1'b1;
    MemWriteAck = 1'b1;
    tick(); #1;
    n_cmp++; if (ForwardHit !== 1'b1 || ForwardData !== 64'd2 || Count !== 3'd1) begin
      n_err++; $display("FAIL fwd_inflight got=%b/%h/%0d exp=1/2/1", ForwardHit, ForwardData, Count); end
    for (int i = 0; i < 10 && Empty !== 1'b1; i++) tick();
    n_cmp++; if (Empty !== 1'b1) begin n_err++; $display("FAIL fwd_drain_timeout empty=%b exp=1", Empty); end
    LoadValid = 1'b0; MemWriteAck = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 64'h40, 64'hA, 1'b0); tick();
    drive(1'b1, 64'h48, 64'hB, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b0); #1;
    n_cmp++; if (Count !== 3'd2 || MemWriteReq !== 1'b1 || MemWriteAddr !== 64'h40) begin
      n_err++; $display("FAIL simul_pre got=%0d/%b/%h exp=2/1/40", Count, MemWriteReq, MemWriteAddr); end
    drive(1'b1, 64'h50, 64'hC, 1'b1); tick();
    drive(1'b0, '0, '0, 1'b0); #1;
    n_cmp++; if (Count !== 3'd2 || MemWriteAddr !== 64'h48 || MemWriteData !== 64'hB) begin
      n_err++; $display("FAIL simul_post got=%0d/%h/%h exp=2/48/b", Count, MemWriteAddr, MemWriteData); end
    MemWriteAck = 1'b1; tick(); #1;
    n_cmp++; if (MemWriteAddr !== 64'h50 || MemWriteData !== 64'hC || Count !== 3'd1) begin
      n_err++; $display("FAIL simul_tail got=%h/%h/%0d exp=50/c/1", MemWriteAddr, MemWriteData, Count); end
    tick(); #1;
    n_cmp++; if (Empty !== 1'b1 || MemWriteReq !== 1'b0) begin n_err++; $display("FAIL simul_empty got=%b/%b exp=1/0", Empty, MemWriteReq); end
    MemWriteAck = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(8 * i + 8), 64'(i), 1'b0); tick();
    end
    drive(1'b0, '0, '0, 1'b0); #1;
    n_cmp++; if (Count !== 3'd3 || MemWriteReq !== 1'b1) begin n_err++; $display("FAIL rmid_pre got=%0d/%b exp=3/1", Count, MemWriteReq); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (MemWriteReq !== 1'b0 || Count !== 3'd0 || Empty !== 1'b1) begin
      n_err++; $display("FAIL rmid_async got=%b/%0d/%b exp=0/0/1", MemWriteReq, Count, Empty); end
    @(negedge clk);
    reset = 1'b1; MemWriteAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_cmp++; if (MemWriteReq !== 1'b0 || Count !== 3'd0) begin n_err++; $display("FAIL rmid_ack%0d got=%b/%0d exp=0/0", i, MemWriteReq, Count); end
    end
    MemWriteAck = 1'b0;
  endtask

  task automatic test_wraparound();
    logic [AW+DW-1:0] mq[$];
    logic [AW+DW-1:0] enq_log[$];
    logic [AW+DW-1:0] mem_log[$];
    logic             req_m;
    logic             en, ack, stall_m, pop_m, push_m, hit_m;
    logic [DW-1:0]    fdat_m;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    int               accepted, old_size, cyc;
    req_m = 1'b0; accepted = 0; cyc = 0;
    while ((accepted < 10 || mq.size() != 0 || req_m) && cyc < 500) begin
      en  = (accepted < 10) && ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) == 0);
      a   = 64'($urandom_range(0, 7)) * 64'd8;
      d   = {$urandom, $urandom};
      drive(en, a, d, ack);
      LoadValid   = $urandom_range(0, 1) == 1;
      LoadAddress = 64'($urandom_range(0, 7)) * 64'd8;
      #1;
      hit_m = 1'b0; fdat_m = '0;
      for (int i = 0; i < mq.size(); i++)
        if (LoadValid && mq[i][AW+DW-1:DW] == LoadAddress) begin hit_m = 1'b1; fdat_m = mq[i][DW-1:0]; end
      n_cmp++; if (Count !== 3'(mq.size()) || Empty !== (mq.size() == 0)) begin
        n_err++; $display("FAIL wrap_count cyc%0d got=%0d/%b exp=%0d", cyc, Count, Empty, mq.size()); end
      n_cmp++; if (StoreStall !== (mq.size() == DEPTH)) begin
        n_err++; $display("FAIL wrap_stall cyc%0d got=%b exp=%b", cyc, StoreStall, mq.size() == DEPTH); end
      n_cmp++; if (MemWriteReq !== req_m) begin n_err++; $display("FAIL wrap_req cyc%0d got=%b exp=%b", cyc, MemWriteReq, req_m); end
      if (req_m && mq.size() > 0) begin
        n_cmp++; if ({MemWriteAddr, MemWriteData} !== mq[0]) begin
          n_err++; $display("FAIL wrap_head cyc%0d got=%h/%h exp=%h", cyc, MemWriteAddr, MemWriteData, mq[0]); end
      end
      n_cmp++; if (ForwardHit !== hit_m || ForwardData !== fdat_m) begin
        n_err++; $display("FAIL wrap_fwd cyc%0d got=%b/%h exp=%b/%h", cyc, ForwardHit, ForwardData, hit_m, fdat_m); end
      stall_m  = (mq.size() == DEPTH);
      pop_m    = req_m && ack;
      push_m   = en && !stall_m;
      old_size = mq.size();
      tick();
      if (pop_m) mem_log.push_back(mq.pop_front());
      if (push_m) begin mq.push_back({a, d}); enq_log.push_back({a, d}); accepted++; end
      if (!req_m) req_m = (old_size > 0);
      else if (pop_m) req_m = (mq.size() > 0);
      cyc++;
    end
    n_cmp++; if (cyc >= 500) begin n_err++; $display("FAIL wrap_timeout cycles=%0d limit=500", cyc); end
    n_cmp++; if (mem_log.size() != enq_log.size() || enq_log.size() != 10) begin
      n_err++; $display("FAIL wrap_len got=%0d exp=%0d (10)", mem_log.size(), enq_log.size()); end
    for (int i = 0; i < mem_log.size() && i < enq_log.size(); i++) begin
      n_cmp++; if (mem_log[i] !== enq_log[i]) begin n_err++; $display("FAIL wrap_order%0d got=%h exp=%h", i, mem_log[i], enq_log[i]); end
    end
    drive(1'b0, '0, '0, 1'b0);
    LoadValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_wraparound();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
